// File: rtl/decimal_entry_writer_pkg.sv
// Purpose : shared types and constants for the decimal entry writer slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, decimal base and largest legal BCD digit.
package decimal_entry_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int        DEC_BASE  = 10;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/decimal_entry_writer_if.sv
// Purpose : register-file write port (request held until accepted).
// Latency : n/a (wires only).
// Backpressure: wr_en/wr_addr/wr_data hold until wr_ack is seen with wr_en high.
//
// Ports: wr_en, wr_addr, wr_data driven by the writer (master); wr_ack by the register file (slave).
interface decimal_entry_writer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/decimal_entry_writer_dec_mac.sv
// Purpose : combinational acc*10 + digit with overflow flag.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports: i_acc (DATA_W), i_digit (4) in; o_sum (DATA_W low bits), o_ovf (product >= 2^DATA_W) out.
module dec_mac #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_acc,
    input  logic [3:0]        i_digit,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_ovf
);
    // Four guard bits: acc*10+9 < 16*2^DATA_W, so the widened sum never wraps.
    logic [DATA_W+3:0] w_ext;
    logic [DATA_W+3:0] w_prod;

    assign w_ext  = {4'b0000, i_acc};
    // x*10 as (x<<3)+(x<<1) keeps this to two adders instead of a multiplier.
    assign w_prod = (w_ext << 3) + (w_ext << 1) + {{DATA_W{1'b0}}, i_digit};
    assign o_sum  = w_prod[DATA_W-1:0];
    assign o_ovf  = |w_prod[DATA_W+3:DATA_W];
endmodule

// File: rtl/decimal_entry_writer.sv
// Purpose : accumulate BCD digits into a binary value and write it to the register file on commit.
// Latency : digit strobe -> o_acc_value in 2 cycles; commit strobe -> wr_en in 1 cycle.
// Backpressure: wr_en held until wr_ack; all strobes dropped (no err) while o_busy.
//
// Ports: i_clk, i_rst_n (sync, active-low), i_digit_in/i_digit_stb, i_commit_stb, i_clear_stb,
//        i_dest_addr, wr_if (write port master), o_acc_value, o_digit_count, o_busy, o_err.
// Build option: OVERFLOW_SAT_EN saturates the accumulator on overflow instead of rejecting the digit.
module decimal_entry_writer
    import decimal_entry_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int MAX_DIGITS = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [3:0]            i_digit_in,
    input  logic                  i_digit_stb,
    input  logic                  i_commit_stb,
    input  logic                  i_clear_stb,
    input  logic [ADDR_W-1:0]     i_dest_addr,
    decimal_entry_writer_if.master wr_if,
    output logic [DATA_W-1:0]     o_acc_value,
    output logic [3:0]            o_digit_count,
    output logic                  o_busy,
    output logic                  o_err
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    state_t              r_state;
    logic [DATA_W-1:0]   r_acc;
    logic [3:0]          r_count;
    logic [3:0]          r_digit;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_err;

    state_t              w_state_nx;
    logic [DATA_W-1:0]   w_acc_nx;
    logic [3:0]          w_count_nx;
    logic [3:0]          w_digit_nx;
    logic [ADDR_W-1:0]   w_wr_addr_nx;
    logic [DATA_W-1:0]   w_wr_data_nx;
    logic                w_err_nx;

    logic [DATA_W-1:0]   w_sum;
    logic                w_ovf;

    // Digit is latched in IDLE and folded in during ACC, which breaks the
    // strobe-to-adder path and gives the fixed 2-cycle echo latency.
    dec_mac #(.DATA_W(DATA_W)) u_dec_mac (
        .i_acc   (r_acc),
        .i_digit (r_digit),
        .o_sum   (w_sum),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_count   <= '0;
            r_digit   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_acc     <= w_acc_nx;
            r_count   <= w_count_nx;
            r_digit   <= w_digit_nx;
            r_wr_addr <= w_wr_addr_nx;
            r_wr_data <= w_wr_data_nx;
            r_err     <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_acc_nx     = r_acc;
        w_count_nx   = r_count;
        w_digit_nx   = r_digit;
        w_wr_addr_nx = r_wr_addr;
        w_wr_data_nx = r_wr_data;
        w_err_nx     = 1'b0;

        unique case (r_state)
            IDLE: begin
                // Strobe priority: clear > commit > digit.
                if (i_clear_stb) begin
                    w_acc_nx   = '0;
                    w_count_nx = '0;
                end else if (i_commit_stb) begin
                    // An empty entry has nothing to write; silently ignore.
                    if (r_count != 4'd0) begin
                        w_wr_addr_nx = i_dest_addr;
                        w_wr_data_nx = r_acc;
                        w_state_nx   = WRITE;
                    end
                end else if (i_digit_stb) begin
                    if ((i_digit_in > DIGIT_MAX) || (r_count == MAX_CNT)) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_digit_nx = i_digit_in;
                        w_state_nx = ACC;
                    end
                end
            end

            ACC: begin
                if (!w_ovf) begin
                    w_acc_nx   = w_sum;
                    w_count_nx = r_count + 4'd1;
                end else begin
`ifdef OVERFLOW_SAT_EN
                    w_acc_nx   = {DATA_W{1'b1}};
                    w_count_nx = r_count + 4'd1;
                    w_err_nx   = 1'b1;
`else
                    w_err_nx   = 1'b1;
`endif
                end
                w_state_nx = IDLE;
            end

            WRITE: begin
                if (wr_if.wr_ack) begin
                    w_acc_nx   = '0;
                    w_count_nx = '0;
                    w_state_nx = IDLE;
                end
            end

            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign wr_if.wr_en   = (r_state == WRITE);
    assign wr_if.wr_addr = r_wr_addr;
    assign wr_if.wr_data = r_wr_data;

    assign o_acc_value   = r_acc;
    assign o_digit_count = r_count;
    assign o_busy        = (r_state != IDLE);
    assign o_err         = r_err;
endmodule

// File: tb/tb_decimal_entry_writer.sv
// Purpose : directed self-checking bench for decimal_entry_writer.
// Latency : inputs driven on negedge, outputs sampled on negedge.
// Backpressure: bench plays the register file and chooses the wr_ack delay.
module tb_decimal_entry_writer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic [3:0]        digit_in;
    logic              digit_stb;
    logic              commit_stb;
    logic              clear_stb;
    logic [ADDR_W-1:0] dest_addr;
    logic [DATA_W-1:0] acc_value;
    logic [3:0]        digit_count;
    logic              busy;
    logic              err;

    int tests;
    int fails;

    decimal_entry_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wr_bus ();

    decimal_entry_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_DIGITS(10)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_digit_in    (digit_in),
        .i_digit_stb   (digit_stb),
        .i_commit_stb  (commit_stb),
        .i_clear_stb   (clear_stb),
        .i_dest_addr   (dest_addr),
        .wr_if         (wr_bus.master),
        .o_acc_value   (acc_value),
        .o_digit_count (digit_count),
        .o_busy        (busy),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One digit strobe; returns err seen in the cycle after the strobe and after the ACC cycle.
    task automatic put_digit(input logic [3:0] d, output logic e1, output logic e2);
        digit_in  = d;
        digit_stb = 1'b1;
        @(negedge clk);
        digit_stb = 1'b0;
        e1 = err;
        @(negedge clk);
        e2 = err;
    endtask

    task automatic enter_value(input longint v, input int n);
        logic   e1, e2;
        longint pw;
        for (int k = n - 1; k >= 0; k--) begin
            pw = 1;
            for (int j = 0; j < k; j++) pw = pw * 10;
            put_digit(4'((v / pw) % 10), e1, e2);
        end
    endtask

    task automatic pulse_commit(input logic [ADDR_W-1:0] a);
        dest_addr  = a;
        commit_stb = 1'b1;
        @(negedge clk);
        commit_stb = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_stb = 1'b1;
        @(negedge clk);
        clear_stb = 1'b0;
    endtask

    // Acts as register file: acks on the ack_delay-th cycle wr_en is seen; bounded wait.
    task automatic serve_write(input int ack_delay, output int en_cycles,
                               output logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        en_cycles = 0;
        a = '0;
        d = '0;
        for (int i = 0; i < 50; i++) begin
            wr_bus.wr_ack = 1'b0;
            if (!wr_bus.wr_en) break;
            en_cycles++;
            a = wr_bus.wr_addr;
            d = wr_bus.wr_data;
            if (en_cycles == ack_delay) wr_bus.wr_ack = 1'b1;
            @(negedge clk);
        end
        wr_bus.wr_ack = 1'b0;
    endtask

    initial begin
        logic              e1, e2;
        int                n;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        digit_in = 4'd0;
        digit_stb = 1'b0;
        commit_stb = 1'b0;
        clear_stb = 1'b0;
        dest_addr = '0;
        wr_bus.wr_ack = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_wr_en",   64'(wr_bus.wr_en), 64'd0);
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_err",     64'(err), 64'd0);
        chk("rst_acc",     64'(acc_value), 64'd0);
        chk("rst_count",   64'(digit_count), 64'd0);
        chk("rst_wr_addr", 64'(wr_bus.wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_bus.wr_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 1,2,3 -> addr 5, ack on third wr_en cycle.
        digit_in  = 4'd1;
        digit_stb = 1'b1;
        @(negedge clk);
        digit_stb = 1'b0;
        chk("t1_busy_acc",  64'(busy), 64'd1);
        chk("t1_acc_lat1",  64'(acc_value), 64'd0);
        @(negedge clk);
        chk("t1_acc_lat2",  64'(acc_value), 64'd1);
        put_digit(4'd2, e1, e2);
        put_digit(4'd3, e1, e2);
        chk("t1_acc",       64'(acc_value), 64'd123);
        chk("t1_count",     64'(digit_count), 64'd3);
        pulse_commit(5'd5);
        serve_write(3, n, a, d);
        chk("t1_en_cycles", 64'(n), 64'd3);
        chk("t1_wr_addr",   64'(a), 64'd5);
        chk("t1_wr_data",   64'(d), 64'd123);
        chk("t1_wr_en_off", 64'(wr_bus.wr_en), 64'd0);
        chk("t1_acc_clr",   64'(acc_value), 64'd0);
        chk("t1_cnt_clr",   64'(digit_count), 64'd0);

        // 2: illegal BCD digit rejected, then 7 accepted.
        put_digit(4'hA, e1, e2);
        chk("t2_err_pulse", 64'(e1), 64'd1);
        chk("t2_err_once",  64'(e2), 64'd0);
        chk("t2_acc",       64'(acc_value), 64'd0);
        chk("t2_count",     64'(digit_count), 64'd0);
        put_digit(4'd7, e1, e2);
        chk("t2_acc7",      64'(acc_value), 64'd7);
        chk("t2_no_err",    64'(e1 | e2), 64'd0);
        pulse_clear();

        // 3: full-scale value, then overflow on the tenth digit.
        enter_value(64'd4294967295, 10);
        chk("t3_acc_max",   64'(acc_value), 64'hFFFF_FFFF);
        chk("t3_count",     64'(digit_count), 64'd10);
        pulse_commit(5'd17);
        serve_write(1, n, a, d);
        chk("t3_en_cycles", 64'(n), 64'd1);
        chk("t3_wr_addr",   64'(a), 64'd17);
        chk("t3_wr_data",   64'(d), 64'hFFFF_FFFF);
        enter_value(64'd429496729, 9);
        put_digit(4'd6, e1, e2);
        chk("t3_ovf_err",   64'(e2), 64'd1);
`ifdef OVERFLOW_SAT_EN
        chk("t3_ovf_acc",   64'(acc_value), 64'hFFFF_FFFF);
        chk("t3_ovf_cnt",   64'(digit_count), 64'd10);
`else
        chk("t3_ovf_acc",   64'(acc_value), 64'd429496729);
        chk("t3_ovf_cnt",   64'(digit_count), 64'd9);
`endif
        pulse_clear();

        // 4: eleventh digit rejected; commit of empty entry ignored.
        enter_value(64'd1234567890, 10);
        put_digit(4'd1, e1, e2);
        chk("t4_err",       64'(e1), 64'd1);
        chk("t4_count",     64'(digit_count), 64'd10);
        chk("t4_acc",       64'(acc_value), 64'd1234567890);
        pulse_clear();
        pulse_commit(5'd3);
        chk("t4_no_wr",     64'(wr_bus.wr_en), 64'd0);
        chk("t4_no_busy",   64'(busy), 64'd0);
        chk("t4_no_err",    64'(err), 64'd0);

        // 5: clear beats commit; digit during ACC dropped.
        put_digit(4'd5, e1, e2);
        clear_stb  = 1'b1;
        commit_stb = 1'b1;
        dest_addr  = 5'd9;
        @(negedge clk);
        clear_stb  = 1'b0;
        commit_stb = 1'b0;
        chk("t5_no_wr",     64'(wr_bus.wr_en), 64'd0);
        chk("t5_acc",       64'(acc_value), 64'd0);
        chk("t5_count",     64'(digit_count), 64'd0);
        digit_in  = 4'd3;
        digit_stb = 1'b1;
        @(negedge clk);
        digit_in  = 4'd4;
        @(negedge clk);
        digit_stb = 1'b0;
        @(negedge clk);
        chk("t5_drop_acc",  64'(acc_value), 64'd3);
        chk("t5_drop_cnt",  64'(digit_count), 64'd1);

        // 6: reset while a write is pending and never acked.
        pulse_commit(5'd30);
        chk("t6_wr_en",     64'(wr_bus.wr_en), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_wr_en_rst", 64'(wr_bus.wr_en), 64'd0);
        chk("t6_busy_rst",  64'(busy), 64'd0);
        chk("t6_acc_rst",   64'(acc_value), 64'd0);
        chk("t6_err_rst",   64'(err), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_write",  64'(wr_bus.wr_en), 64'd0);
        chk("t6_no_err",    64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
